// File: rtl/pipe_pkg.sv
// Shared definitions for the memory pipeline stage: access-size encodings and FSM state type.
package pipe_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: little-endian load extraction/extension and store
// replication/byte enables. Misaligned halves/words are forced onto aligned lanes.
module mem_align
  import pipe_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_sext,
  input  logic [1:0]  i_lane,
  input  logic        i_we,
  input  logic [31:0] i_st,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ld
);

  logic [7:0]  w_b;
  logic [15:0] w_h;

  always_comb begin
    w_b     = i_rdata[{i_lane, 3'b000} +: 8];
    w_h     = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_be    = 4'b1111;
    o_wdata = i_st;
    o_ld    = i_rdata;
    case (i_size)
      SZ_BYTE: begin
        o_ld = {{24{i_sext & w_b[7]}}, w_b};
        if (i_we) begin
          o_wdata = {4{i_st[7:0]}};
          o_be    = 4'b0001 << i_lane;
        end
      end
      SZ_HALF: begin
        o_ld = {{16{i_sext & w_h[15]}}, w_h};
        if (i_we) begin
          o_wdata = {2{i_st[15:0]}};
          o_be    = 4'b0011 << {i_lane[1], 1'b0};
        end
      end
      default: begin
        o_ld = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/pipe_mem.sv
// Memory stage: issues one RAM transaction per load/store, stalls upstream until ack
// or timeout. Define MEM_ALIGN_CHECK_EN to reject misaligned half/word accesses.
module pipe_mem
  import pipe_pkg::*;
#(
  parameter int unsigned RAM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        e_valid,
  input  logic        e_wreg,
  input  logic        e_m2reg,
  input  logic        e_wmem,
  input  logic [1:0]  e_size,
  input  logic        e_sext,
  input  logic [4:0]  e_wa,
  input  logic [31:0] e_wd,
  input  logic [31:0] e_st,
  output logic        stall,
  output logic        ram_req,
  output logic        ram_we,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic        ram_ack,
  input  logic [31:0] ram_rdata,
  output logic        m_wreg,
  output logic [4:0]  m_wa,
  output logic [31:0] m_wd,
  output logic        m_err
);

  localparam int unsigned CW = (RAM_TIMEOUT < 2) ? 1 : $clog2(RAM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(RAM_TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [1:0]  r_size, w_size;
  logic        r_sext, w_sext;
  logic [1:0]  r_lane, w_lane;
  logic        r_wreg, w_wreg;
  logic        r_load, w_load;
  logic [4:0]  r_wa, w_wa;

  logic        w_req, w_we, w_m_wreg, w_m_err;
  logic [3:0]  w_be_nxt;
  logic [31:0] w_addr, w_wdata_nxt, w_m_wd;
  logic [4:0]  w_m_wa;

  logic        w_mem_op, w_misalign, w_tmo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ld;

  assign w_mem_op = e_valid & (e_m2reg | e_wmem);
  assign w_tmo    = (r_cnt == TMO_LAST);
  assign stall    = (r_state == BUSY);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = ((e_size == SZ_HALF) && e_wd[0]) ||
                      ((e_size != SZ_BYTE) && (e_size != SZ_HALF) && (e_wd[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // One aligner serves both phases: store lanes from execute in IDLE, load lanes from the capture in BUSY.
  mem_align u_align (
    .i_size  ((r_state == IDLE) ? e_size : r_size),
    .i_sext  ((r_state == IDLE) ? e_sext : r_sext),
    .i_lane  ((r_state == IDLE) ? e_wd[1:0] : r_lane),
    .i_we    (e_wmem),
    .i_st    (e_st),
    .i_rdata (ram_rdata),
    .o_be    (w_be),
    .o_wdata (w_wdata),
    .o_ld    (w_ld)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_mem_op && !w_misalign) w_state_nxt = BUSY;
      BUSY: if (ram_ack || w_tmo)        w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_req       = ram_req;
    w_we        = ram_we;
    w_be_nxt    = ram_be;
    w_addr      = ram_addr;
    w_wdata_nxt = ram_wdata;
    w_m_wreg    = 1'b0;
    w_m_wa      = m_wa;
    w_m_wd      = m_wd;
    w_m_err     = 1'b0;
    w_cnt       = r_cnt;
    w_size      = r_size;
    w_sext      = r_sext;
    w_lane      = r_lane;
    w_wreg      = r_wreg;
    w_load      = r_load;
    w_wa        = r_wa;
    case (r_state)
      IDLE: begin
        if (e_valid && !w_mem_op) begin
          w_m_wreg = e_wreg;
          w_m_wa   = e_wa;
          w_m_wd   = e_wd;
        end else if (w_mem_op && w_misalign) begin
          w_m_err = 1'b1;
        end else if (w_mem_op) begin
          w_req       = 1'b1;
          w_we        = e_wmem;
          w_be_nxt    = w_be;
          w_addr      = {e_wd[31:2], 2'b00};
          w_wdata_nxt = w_wdata;
          w_cnt       = '0;
          w_size      = e_size;
          w_sext      = e_sext;
          w_lane      = e_wd[1:0];
          w_wreg      = e_wreg;
          w_load      = !e_wmem;
          w_wa        = e_wa;
        end
      end
      BUSY: begin
        if (ram_ack) begin
          w_req = 1'b0;
          if (r_load) begin
            w_m_wreg = r_wreg;
            w_m_wa   = r_wa;
            w_m_wd   = w_ld;
          end
        end else if (w_tmo) begin
          w_req   = 1'b0;
          w_m_err = 1'b1;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_be    <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      m_wreg    <= 1'b0;
      m_wa      <= '0;
      m_wd      <= '0;
      m_err     <= 1'b0;
      r_cnt     <= '0;
      r_size    <= SZ_BYTE;
      r_sext    <= 1'b0;
      r_lane    <= '0;
      r_wreg    <= 1'b0;
      r_load    <= 1'b0;
      r_wa      <= '0;
    end else begin
      ram_req   <= w_req;
      ram_we    <= w_we;
      ram_be    <= w_be_nxt;
      ram_addr  <= w_addr;
      ram_wdata <= w_wdata_nxt;
      m_wreg    <= w_m_wreg;
      m_wa      <= w_m_wa;
      m_wd      <= w_m_wd;
      m_err     <= w_m_err;
      r_cnt     <= w_cnt;
      r_size    <= w_size;
      r_sext    <= w_sext;
      r_lane    <= w_lane;
      r_wreg    <= w_wreg;
      r_load    <= w_load;
      r_wa      <= w_wa;
    end
  end

endmodule

// File: doc/pipe_mem.md
PIPE_MEM -- requirements
Module: pipe_mem

Interface
REQ-001 SHALL have parameter RAM_TIMEOUT, default 255, max cycles to wait for ram_ack before aborting.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port clrn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have inputs from execute: e_valid 1, e_wreg 1, e_m2reg 1 (load), e_wmem 1 (store), e_size 2 (00 byte, 01 half, 10 word), e_sext 1 (sign-extend load), e_wa 5 (write-back address), e_wd 32 (ALU result/address), e_st 32 (store data).
REQ-005 SHALL have port stall  output  1  holds execute and upstream stages.
REQ-006 SHALL have external RAM ports: ram_req out 1, ram_we out 1, ram_be out 4, ram_addr out 32, ram_wdata out 32, ram_ack in 1, ram_rdata in 32.
REQ-007 SHALL have write-back outputs: m_wreg out 1, m_wa out 5, m_wd out 32, m_err out 1.

Function
REQ-008 SHALL implement states IDLE and BUSY; stall = (state == BUSY).
REQ-009 In IDLE, non-memory op (e_valid, !e_m2reg, !e_wmem) SHALL register m_wreg=e_wreg, m_wa=e_wa, m_wd=e_wd at next edge (latency 1).
REQ-010 In IDLE, memory op SHALL at next edge capture wa/size/sext/wreg, register ram_req=1, ram_addr={e_wd[31:2],2'b00}, ram_we=e_wmem, ram_be, ram_wdata, enter BUSY, and write m_wreg=0 (bubble).
REQ-011 In BUSY, ram_req/ram_addr/ram_we/ram_be/ram_wdata SHALL hold stable until the edge sampling ram_ack=1.
REQ-012 On ram_ack in BUSY, SHALL at that edge drop ram_req, return to IDLE, and for loads write m_wreg=captured wreg, m_wa, m_wd=aligned load data; for stores m_wreg=0.
REQ-013 While BUSY with no ack, m_wreg SHALL be 0 each cycle.
REQ-014 Loads little-endian: byte lane = addr[1:0], half lane = addr[1]; result zero- or sign-extended per e_sext to 32 bits.
REQ-015 Stores: byte replicated to all lanes, ram_be=4'b0001<<addr[1:0]; half replicated, ram_be=4'b0011<<{addr[1],1'b0}; word ram_be=4'b1111; loads ram_be=4'b1111.
REQ-016 Timeout counter SHALL clear on BUSY entry and increment each BUSY cycle; at RAM_TIMEOUT with no ack SHALL drop ram_req, pulse m_err=1 one cycle, m_wreg=0, return to IDLE.
REQ-017 Ack coinciding with timeout SHALL complete normally (ack wins, no m_err).
REQ-018 e_valid=0 in IDLE SHALL write m_wreg=0, m_err=0; m_err SHALL be 0 except REQ-016/REQ-021.

Reset
REQ-019 clrn low SHALL immediately force state IDLE, stall=0, ram_req=0, ram_we=0, ram_be=0, ram_addr=0, ram_wdata=0, m_wreg=0, m_wa=0, m_wd=0, m_err=0, counter=0, including mid-transaction.

Configuration
REQ-020 Macro MEM_ALIGN_CHECK_EN SHALL enable misalignment detection.
REQ-021 With it defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL issue no request, stay IDLE, and pulse m_err=1 with m_wreg=0 next cycle.
REQ-022 Without it: offending low address bits SHALL be ignored (forced aligned) and access proceeds normally.

Structure
REQ-023 Shared package pipe_pkg SHALL hold size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state type.
REQ-024 Sub-module mem_align SHALL implement combinational load extraction/extension and store lane replication/byte enables.

Verification
REQ-025 Non-mem op e_wd=32'h1234_5678, e_wa=5, wreg=1 -> next cycle m_wd=32'h1234_5678, m_wa=5, m_wreg=1, stall=0.
REQ-026 Load byte sext, addr 32'h100 + 3, rdata 32'h80FF_0000, ack after 3 cycles -> stall 3 cycles, m_wd=32'hFFFF_FF80.
REQ-027 Store half addr 32'h202, e_st=32'h0000_BEEF -> ram_be=4'b1100, ram_wdata=32'hBEEF_BEEF, ram_addr=32'h200, m_wreg=0.
REQ-028 No ack, RAM_TIMEOUT=4 -> ram_req drops after 4 BUSY cycles, m_err one-cycle pulse, stall released.
REQ-029 Word load addr 32'h101 -> with MEM_ALIGN_CHECK_EN m_err=1, no ram_req; without, ram_addr=32'h100, normal completion.
REQ-030 clrn low during BUSY -> ram_req, stall, m_wreg 0 immediately; after release, next op accepted from IDLE.
